dds_freq_meter: RTL and testbench

Frequency measurement receiver for the DDS sine output path. It takes a stream of 8-bit offset-binary samples, detects rising midscale crossings with hysteresis, and reports the sample count spanning a fixed number of signal periods. It lets loopback benches and on-chip self-test verify a frequency control word against the generated tone.

---
 rtl/dds_pkg.sv | 20 ++
 rtl/schmitt_detect.sv | 55 +++++
 rtl/dds_freq_meter.sv | 133 +++++++++++++
 tb/tb_dds_freq_meter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and helpers for the DDS frequency measurement path.
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } meas_state_t;

    typedef enum logic [1:0] {
        UNK,
        LO,
        HI
    } lvl_t;

    function automatic int unsigned dds_mid(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/schmitt_detect.sv
// Three-state level tracker with hysteresis around midscale; flags LO->HI
// transitions on the sample that causes them.
module schmitt_detect
    import dds_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int HYST     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_sample,
    output logic                rise,
    output lvl_t                lvl
);

    localparam int MID = int'(dds_mid(SAMPLE_W));
    // One extra bit so MID+HYST cannot wrap for wide hysteresis settings.
    localparam logic [SAMPLE_W:0] HI_TH = (SAMPLE_W + 1)'(MID + HYST);
    localparam logic [SAMPLE_W:0] LO_TH = (SAMPLE_W + 1)'(MID - HYST);

    lvl_t lvl_q;
    lvl_t lvl_d;
    logic is_hi;
    logic is_lo;

    assign is_hi = ({1'b0, in_sample} >= HI_TH);
    assign is_lo = ({1'b0, in_sample} <= LO_TH);

    assign rise = in_valid && (lvl_q == LO) && is_hi;
    assign lvl  = lvl_q;

    always_comb begin
        lvl_d = lvl_q;
        if (clr) begin
            lvl_d = UNK;
        end else if (in_valid) begin
            if (is_hi) begin
                lvl_d = HI;
            end else if (is_lo) begin
                lvl_d = LO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q <= UNK;
        end else begin
            lvl_q <= lvl_d;
        end
    end

endmodule

// File: rtl/dds_freq_meter.sv
// Counts valid samples spanning 2**PERIODS_LOG2 rising midscale crossings
// and publishes the total; windows run back to back once armed.
module dds_freq_meter
    import dds_pkg::*;
#(
    parameter int SAMPLE_W     = 8,
    parameter int HYST         = 8,
    parameter int PERIODS_LOG2 = 4,
    parameter int CNT_W        = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_sample,
    output logic [CNT_W-1:0]    period_sum,
    output logic                meas_valid,
    output logic                locked,
    output logic                timeout
);

    localparam logic [CNT_W-1:0]        CNT_MAX    = '1;
    localparam logic [PERIODS_LOG2-1:0] TALLY_LAST = '1;

    meas_state_t             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PERIODS_LOG2-1:0] tally_q, tally_d;
    logic [CNT_W-1:0]        psum_q, psum_d;
    logic                    meas_q, meas_d;
    logic                    locked_q, locked_d;
    logic                    timeout_q, timeout_d;

    logic rise;
    lvl_t trk_lvl_unused;

    // Dropping en forces the tracker back to UNK so a re-arm needs a fresh LO.
    schmitt_detect #(
        .SAMPLE_W (SAMPLE_W),
        .HYST     (HYST)
    ) u_schmitt (
        .clk       (clk),
        .rst       (rst),
        .clr       (~en),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .rise      (rise),
        .lvl       (trk_lvl_unused)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tally_d   = tally_q;
        psum_d    = psum_q;
        meas_d    = 1'b0;
        timeout_d = 1'b0;
        locked_d  = locked_q;

        if (!en) begin
            state_d  = IDLE;
            cnt_d    = '0;
            tally_d  = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    tally_d = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = '0;
                        tally_d = '0;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (in_valid) begin
                        // A crossing outranks saturation on the same sample.
                        if (rise) begin
                            if (tally_q == TALLY_LAST) begin
                                psum_d   = cnt_q + 1'b1;
                                meas_d   = 1'b1;
                                locked_d = 1'b1;
                                cnt_d    = '0;
                                tally_d  = '0;
                            end else begin
                                tally_d = tally_q + 1'b1;
                                cnt_d   = cnt_q + 1'b1;
                            end
                        end else if (cnt_q == CNT_MAX) begin
                            timeout_d = 1'b1;
                            locked_d  = 1'b0;
                            state_d   = ARM;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tally_q   <= '0;
            psum_q    <= '0;
            meas_q    <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tally_q   <= tally_d;
            psum_q    <= psum_d;
            meas_q    <= meas_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_sum = psum_q;
    assign meas_valid = meas_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Scoreboard bench: a behavioural model predicts every meas_valid/timeout
// pulse (value, cycle) as samples are driven; a monitor pops and compares.
module tb_dds_freq_meter;

    localparam int CMAX0 = 16777215;
    localparam int CMAX1 = 255;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       en0       = 1'b0;
    logic       en1       = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_sample = 8'h80;

    logic rst_nx = 1'b1;
    logic en0_nx = 1'b0;
    logic en1_nx = 1'b0;

    logic [23:0] psum0;
    logic        mv0, lk0, to0;
    logic [7:0]  psum1;
    logic        mv1, lk1, to1;

    int total    = 0;
    int bad      = 0;
    int edge_cnt = 0;
    int ph       = 0;
    int j        = 0;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    int m_lvl[2]   = '{0, 0};
    int m_st[2]    = '{0, 0};
    int m_cnt[2]   = '{0, 0};
    int m_tally[2] = '{0, 0};
    int m_psum[2]  = '{0, 0};

    dds_freq_meter #(
        .SAMPLE_W(8), .HYST(8), .PERIODS_LOG2(4), .CNT_W(24)
    ) dut0 (
        .clk(clk), .rst(rst), .en(en0), .in_valid(in_valid), .in_sample(in_sample),
        .period_sum(psum0), .meas_valid(mv0), .locked(lk0), .timeout(to0)
    );

    dds_freq_meter #(
        .SAMPLE_W(8), .HYST(8), .PERIODS_LOG2(4), .CNT_W(8)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en1), .in_valid(in_valid), .in_sample(in_sample),
        .period_sum(psum1), .meas_valid(mv1), .locked(lk1), .timeout(to1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_ev(input int d, input int kind, input int val, input int cyc);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = cyc;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Reference behaviour for one accepted edge of instance d.
    task automatic model_step(input int d, input logic en_s, input int cmax);
        int   old_lvl;
        logic rise;
        if (rst || !en_s) begin
            m_lvl[d] = 0;
            m_st[d]  = 0;
            if (rst) m_psum[d] = 0;
            return;
        end
        old_lvl = m_lvl[d];
        if (in_valid) begin
            if (int'(in_sample) >= 136)      m_lvl[d] = 2;
            else if (int'(in_sample) <= 120) m_lvl[d] = 1;
        end
        rise = in_valid && (old_lvl == 1) && (m_lvl[d] == 2);
        case (m_st[d])
            0: m_st[d] = 1;
            1: if (rise) begin
                m_st[d]    = 2;
                m_cnt[d]   = 0;
                m_tally[d] = 0;
            end
            default: if (in_valid) begin
                if (rise) begin
                    m_tally[d] = m_tally[d] + 1;
                    if (m_tally[d] == 16) begin
                        m_psum[d] = (m_cnt[d] + 1) & cmax;
                        push_ev(d, 0, m_psum[d], edge_cnt + 1);
                        m_cnt[d]   = 0;
                        m_tally[d] = 0;
                    end else begin
                        m_cnt[d] = m_cnt[d] + 1;
                    end
                end else if (m_cnt[d] == cmax) begin
                    push_ev(d, 1, m_psum[d], edge_cnt + 1);
                    m_st[d] = 1;
                end else begin
                    m_cnt[d] = m_cnt[d] + 1;
                end
            end
        endcase
    endtask

    task automatic drive(input logic v, input logic [7:0] s);
        @(posedge clk);
        #1;
        rst       = rst_nx;
        en0       = en0_nx;
        en1       = en1_nx;
        in_valid  = v;
        in_sample = s;
        model_step(0, en0, CMAX0);
        model_step(1, en1, CMAX1);
    endtask

    function automatic logic [7:0] sine_at(input int i);
        real r;
        int  k;
        r = 100.0 * $sin(6.283185307179586 * real'(i) / 64.0);
        k = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        return 8'(128 + k);
    endfunction

    function automatic logic [7:0] dith_at(input int i);
        return 8'(int'(sine_at(i)) + (((i % 2) != 0) ? 4 : -4));
    endfunction

    function automatic logic [7:0] sq(input int k);
        return (((k >> 2) & 1) != 0) ? 8'hFF : 8'h00;
    endfunction

    task automatic mon_dut(input int d, input logic mv, input logic to,
                           input logic [31:0] ps, input logic lk);
        ev_t e;
        int  qn;
        if (mv || to) begin
            qn = (d == 0) ? q0.size() : q1.size();
            if (qn == 0) begin
                check_eq($sformatf("d%0d_unexpected_pulse", d), {30'd0, to, mv}, 32'd0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check_eq($sformatf("d%0d_kind", d), {31'd0, to}, e.kind);
                check_eq($sformatf("d%0d_cycle", d), edge_cnt, e.cyc);
                check_eq($sformatf("d%0d_psum", d), ps, e.val);
                check_eq($sformatf("d%0d_locked_at_pulse", d), {31'd0, lk}, (e.kind == 0) ? 1 : 0);
            end
        end
    endtask

    always @(negedge clk) begin
        mon_dut(0, mv0, to0, 32'(psum0), lk0);
        mon_dut(1, mv1, to1, 32'(psum1), lk1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) drive(1'b0, 8'h80);
        rst_nx = 1'b0;
        drive(1'b0, 8'h80);
        @(negedge clk);
        check_eq("rst_psum0", 32'(psum0), 32'd0);
        check_eq("rst_meas0", {31'd0, mv0}, 32'd0);
        check_eq("rst_lock0", {31'd0, lk0}, 32'd0);
        check_eq("rst_tout0", {31'd0, to0}, 32'd0);
        check_eq("rst_psum1", 32'(psum1), 32'd0);
        check_eq("rst_lock1", {31'd0, lk1}, 32'd0);

        // Clean 64-sample sine on the wide instance.
        en0_nx = 1'b1;
        repeat (3300) begin drive(1'b1, sine_at(ph)); ph++; end
        @(negedge clk);
        check_eq("sine_psum", 32'(psum0), 32'd1024);
        check_eq("sine_lock", {31'd0, lk0}, 32'd1);

        // Dither inside the hysteresis band must not add crossings.
        repeat (2200) begin drive(1'b1, dith_at(ph)); ph++; end
        @(negedge clk);
        check_eq("noise_psum", 32'(psum0), 32'd1024);
        check_eq("noise_lock", {31'd0, lk0}, 32'd1);

        // Abort a window with en, then resume.
        repeat (500) begin drive(1'b1, sine_at(ph)); ph++; end
        en0_nx = 1'b0;
        repeat (20) begin drive(1'b1, sine_at(ph)); ph++; end
        @(negedge clk);
        check_eq("endrop_lock", {31'd0, lk0}, 32'd0);
        check_eq("endrop_psum_hold", 32'(psum0), 32'd1024);
        en0_nx = 1'b1;
        repeat (2200) begin drive(1'b1, sine_at(ph)); ph++; end
        @(negedge clk);
        check_eq("resume_psum", 32'(psum0), 32'd1024);
        check_eq("resume_lock", {31'd0, lk0}, 32'd1);

        // Square wave with in_valid toggling; invalid cycles carry a high value.
        en0_nx = 1'b0;
        drive(1'b0, 8'h00);
        en0_nx = 1'b1;
        j = 0;
        for (int c = 0; c < 5200; c++) begin
            if ((c % 2) == 0) begin drive(1'b1, sq(j)); j++; end
            else              drive(1'b0, 8'hAA);
        end
        @(negedge clk);
        check_eq("sqtog_psum", 32'(psum0), 32'd128);
        check_eq("sqtog_lock", {31'd0, lk0}, 32'd1);

        // Both instances: lock on a continuous square, then saturate the 8-bit one.
        en0_nx = 1'b0;
        drive(1'b0, 8'h00);
        en0_nx = 1'b1;
        en1_nx = 1'b1;
        j = 0;
        repeat (424) begin drive(1'b1, sq(j)); j++; end
        @(negedge clk);
        check_eq("sq8_psum", 32'(psum1), 32'd128);
        check_eq("sq8_lock", {31'd0, lk1}, 32'd1);
        repeat (300) drive(1'b1, 8'h80);
        @(negedge clk);
        check_eq("sat_psum_hold", 32'(psum1), 32'd128);
        check_eq("sat_lock", {31'd0, lk1}, 32'd0);
        check_eq("wide_lock_kept", {31'd0, lk0}, 32'd1);
        check_eq("wide_psum_kept", 32'(psum0), 32'd128);

        // Reset in the middle of a window clears every output on the next cycle.
        repeat (50) begin drive(1'b1, sq(j)); j++; end
        rst_nx = 1'b1;
        drive(1'b1, sq(j));
        j++;
        rst_nx = 1'b0;
        drive(1'b0, 8'h00);
        @(negedge clk);
        check_eq("midrst_psum0", 32'(psum0), 32'd0);
        check_eq("midrst_psum1", 32'(psum1), 32'd0);
        check_eq("midrst_lock0", {31'd0, lk0}, 32'd0);
        check_eq("midrst_lock1", {31'd0, lk1}, 32'd0);
        check_eq("midrst_meas0", {31'd0, mv0}, 32'd0);
        check_eq("midrst_tout1", {31'd0, to1}, 32'd0);

        repeat (10) drive(1'b0, 8'h00);
        @(negedge clk);
        check_eq("q0_drained", q0.size(), 32'd0);
        check_eq("q1_drained", q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
